// File: rtl/data_pipe_pkg.sv
// Shared definitions for the data_pipe demux/interconnect family: buffer FSM
// states, path count and a path decode helper.
package data_pipe_pkg;

  localparam int NPATH  = 8;
  localparam int PSEL_W = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } demux_state_e;

  function automatic logic [NPATH-1:0] path_onehot(input logic [PSEL_W-1:0] path);
    logic [NPATH-1:0] onehot;
    onehot = {{(NPATH-1){1'b0}}, 1'b1};
    return onehot << path;
  endfunction

endpackage

// File: rtl/data_pipe_skid.sv
// Two-entry registered skid buffer: main feeds the output, skid catches one
// word while the output stalls. Ready, valid and data are all registered.
import data_pipe_pkg::*;

module data_pipe_skid #(
  parameter int DSIZE = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             vld_sw,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  input  logic             out_ready,
  output logic             empty_next
);

  demux_state_e     state_r;
  demux_state_e     state_nxt_s;
  logic [DSIZE-1:0] main_data_r;
  logic [DSIZE-1:0] skid_data_r;
  logic             main_vld_r;
  logic             in_ready_r;
  logic             acc_s;
  logic             drn_s;

  assign acc_s = in_valid & in_ready_r & clk_en;
  assign drn_s = main_vld_r & out_ready & clk_en;

  // Next-state decode; unreachable encodings fall back to EMPTY.
  always_comb begin
    state_nxt_s = EMPTY;
    case (state_r)
      EMPTY: begin
        if (acc_s) state_nxt_s = ONE;
        else       state_nxt_s = EMPTY;
      end
      ONE: begin
        if (acc_s && !drn_s)      state_nxt_s = FULL;
        else if (!acc_s && drn_s) state_nxt_s = EMPTY;
        else                      state_nxt_s = ONE;
      end
      FULL: begin
        if (drn_s) state_nxt_s = ONE;
        else       state_nxt_s = FULL;
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Buffer registers, FSM state and registered upstream ready.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      main_data_r <= {DSIZE{1'b0}};
      skid_data_r <= {DSIZE{1'b0}};
      main_vld_r  <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= vld_sw & (state_nxt_s != FULL);
      case (state_r)
        EMPTY: begin
          if (acc_s) begin
            main_data_r <= in_data;
            main_vld_r  <= 1'b1;
          end
        end
        ONE: begin
          if (acc_s && drn_s) begin
            main_data_r <= in_data;
          end else if (acc_s) begin
            skid_data_r <= in_data;
          end else if (drn_s) begin
            main_vld_r <= 1'b0;
          end
        end
        FULL: begin
          if (drn_s) main_data_r <= skid_data_r;
        end
        default: main_vld_r <= 1'b0;
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = main_vld_r;
  assign out_data   = main_data_r;
  assign empty_next = (state_nxt_s == EMPTY);

endmodule

// File: rtl/data_pipe_demux.sv
// One-to-eight valid/ready stream router with a registered skid buffer.
// Optional transfer counter enabled by DATA_PIPE_DEMUX_CNT_EN.
import data_pipe_pkg::*;

module data_pipe_demux #(
  parameter int DSIZE = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              vld_sw,
  input  logic [PSEL_W-1:0] sw,
  output logic [PSEL_W-1:0] curr_path,
  input  logic              s00_valid,
  input  logic [DSIZE-1:0]  s00_data,
  output logic              s00_ready,
  output logic              m00_valid,
  output logic [DSIZE-1:0]  m00_data,
  input  logic              m00_ready,
  output logic              m01_valid,
  output logic [DSIZE-1:0]  m01_data,
  input  logic              m01_ready,
  output logic              m02_valid,
  output logic [DSIZE-1:0]  m02_data,
  input  logic              m02_ready,
  output logic              m03_valid,
  output logic [DSIZE-1:0]  m03_data,
  input  logic              m03_ready,
  output logic              m04_valid,
  output logic [DSIZE-1:0]  m04_data,
  input  logic              m04_ready,
  output logic              m05_valid,
  output logic [DSIZE-1:0]  m05_data,
  input  logic              m05_ready,
  output logic              m06_valid,
  output logic [DSIZE-1:0]  m06_data,
  input  logic              m06_ready,
  output logic              m07_valid,
  output logic [DSIZE-1:0]  m07_data,
  input  logic              m07_ready
`ifdef DATA_PIPE_DEMUX_CNT_EN
  ,
  output logic [15:0]       xfer_cnt
`endif
);

  logic [PSEL_W-1:0] curr_path_r;
  logic [NPATH-1:0]  m_ready_s;
  logic [NPATH-1:0]  m_valid_s;
  logic              out_ready_s;
  logic              out_valid_s;
  logic [DSIZE-1:0]  out_data_s;
  logic              empty_next_s;
  logic              path_load_s;

  assign m_ready_s = {m07_ready, m06_ready, m05_ready, m04_ready,
                      m03_ready, m02_ready, m01_ready, m00_ready};

  // Only the ready of the path in use can drain the buffer.
  assign out_ready_s = m_ready_s[curr_path_r];

  data_pipe_skid #(.DSIZE(DSIZE)) u_skid (
    .clock      (clock),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .vld_sw     (vld_sw),
    .in_valid   (s00_valid),
    .in_data    (s00_data),
    .in_ready   (s00_ready),
    .out_valid  (out_valid_s),
    .out_data   (out_data_s),
    .out_ready  (out_ready_s),
    .empty_next (empty_next_s)
  );

  // The path may only move when the buffer is (or stays) empty, so no word splits.
  assign path_load_s = clk_en & empty_next_s;

  // Current path register.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      curr_path_r <= {PSEL_W{1'b0}};
    end else if (path_load_s) begin
      curr_path_r <= sw;
    end else begin
      curr_path_r <= curr_path_r;
    end
  end

  assign curr_path = curr_path_r;
  assign m_valid_s = out_valid_s ? path_onehot(curr_path_r) : {NPATH{1'b0}};

  assign m00_valid = m_valid_s[0];
  assign m01_valid = m_valid_s[1];
  assign m02_valid = m_valid_s[2];
  assign m03_valid = m_valid_s[3];
  assign m04_valid = m_valid_s[4];
  assign m05_valid = m_valid_s[5];
  assign m06_valid = m_valid_s[6];
  assign m07_valid = m_valid_s[7];

  assign m00_data = out_data_s;
  assign m01_data = out_data_s;
  assign m02_data = out_data_s;
  assign m03_data = out_data_s;
  assign m04_data = out_data_s;
  assign m05_data = out_data_s;
  assign m06_data = out_data_s;
  assign m07_data = out_data_s;

`ifdef DATA_PIPE_DEMUX_CNT_EN
  logic [15:0] xfer_cnt_r;
  logic        drn_s;

  assign drn_s = out_valid_s & out_ready_s & clk_en;

  // Drain counter: cleared when the path changes, saturating otherwise.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      xfer_cnt_r <= 16'h0000;
    end else if (path_load_s && (sw != curr_path_r)) begin
      xfer_cnt_r <= 16'h0000;
    end else if (drn_s && (xfer_cnt_r != 16'hFFFF)) begin
      xfer_cnt_r <= xfer_cnt_r + 16'h0001;
    end else begin
      xfer_cnt_r <= xfer_cnt_r;
    end
  end

  assign xfer_cnt = xfer_cnt_r;
`endif

endmodule

// File: doc/data_pipe_demux.md
# data_pipe_demux

One-to-eight router for `data_inf` valid/ready streams: a single upstream slave port `s00` is steered to one of eight downstream master ports `m00`..`m07`, selected by `sw`. It is the fan-out counterpart of the eight-to-one pipe interconnect, and the two are used back-to-back to share one data path between several producers and consumers. A two-entry registered skid buffer gives full throughput with registered ready and valid. The selected path changes only while the buffer is empty, so no word is ever split across paths.

## Interface
- `DSIZE`, default 8: data width of every stream port.
- `clock`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `clk_en`  in  1  transfer enable. A handshake on any port counts only when `clk_en`=1.
- `vld_sw`  in  1  path enable. While 0, upstream ready is withheld.
- `sw`  in  3  requested output path.
- `curr_path`  out  3  path currently in use.
- `s00`  data_inf.slaver  DSIZE  upstream input (`valid`, `data`, `ready`).
- `m00`..`m07`  data_inf.master  DSIZE each  downstream outputs (`valid`, `data`, `ready`).

## Operation
- **Buffer:** `main` register (`main_data`, `main_vld`) feeds the outputs; `skid` register (`skid_data`) catches one word when downstream stalls.
- **FSM states:**
  - EMPTY: main and skid both invalid.
  - ONE: main valid.
  - FULL: main and skid valid.
- **Events:**
  - `acc` = `s00.valid` & `s00.ready` & `clk_en`.
  - `drn` = `main_vld` & `m[curr_path].ready` & `clk_en`.
- **Transitions:**
  - EMPTY: `acc` → ONE (main ← `s00.data`).
  - ONE:
    - `acc` & `drn` → ONE (main ← `s00.data`).
    - `acc` & !`drn` → FULL (skid ← `s00.data`).
    - !`acc` & `drn` → EMPTY.
    - else stay in ONE.
  - FULL: `drn` → ONE (main ← skid). `acc` cannot occur because ready is low.
  - Unreachable encodings → EMPTY.
- **Upstream ready:** `s00.ready` is registered and equals `vld_sw` & (next state != FULL).
- **Outputs:**
  - `m[curr_path].valid` = `main_vld`; the other seven valids = 0.
  - `data` = `main_data` on all eight ports.
  - Readies of unselected ports are ignored.
- **Path select:** `curr_path` ← `sw` on every cycle whose next state is EMPTY; it is held otherwise.
- **Path change while busy:**
  - Any `sw` change while in ONE or FULL is deferred until the buffer drains.
  - The last word always leaves on the old path.
- **Path enable:** `vld_sw`=0 blocks new accepts from the next cycle on. Words already buffered still drain.
- **`clk_en`=0:** no accept, no drain. State, data and `curr_path` hold. `s00.ready` may still follow `vld_sw`.
- **Reset mid-operation:** buffered words are discarded without warning.

## Timing
- **Reset values:**
  - `curr_path`=0.
  - `s00.ready`=0.
  - All `m*.valid`=0.
  - `main_data`/`skid_data`=0.
  - State EMPTY.
- **Latency:** a word accepted at edge N is valid on `m[curr_path]` after edge N; its first drain opportunity is edge N+1.
- **Throughput:** one word per cycle while downstream is ready.
- **Ready after FULL:** after FULL is entered, `s00.ready` is low in the following cycle, with no combinational path from `m*.ready` to `s00.ready`.
- **Path switch gap:**
  - `sw` is sampled at the edge where the buffer goes or stays EMPTY.
  - The first word on the new path appears no earlier than 2 edges after the last drain on the old path.
- **Simultaneous accept and drain:**
  - In ONE: stays ONE, count unchanged.
  - In FULL: not possible.

## Configuration
- Macro `DATA_PIPE_DEMUX_CNT_EN`.
- **Defined:**
  - Adds output `xfer_cnt` (16 bits), reset 0.
  - Increments on every `drn`; saturates at 16'hFFFF.
  - Cleared on any cycle where `curr_path` loads a different value.
- **Undefined:** no port and no logic. Datapath behaviour is identical in both builds.

## Structure
- **Shared package `data_pipe_pkg`:**
  - FSM enum `demux_state_e` {EMPTY, ONE, FULL}, also reused by the interconnect.
  - `localparam` NPATH=8 and PSEL_W=3.
- **Sub-module `data_pipe_skid`:**
  - Owns the two-entry buffer, the FSM and registered ready.
  - Ports: in valid/data/ready, out valid/data/ready, `clk_en`, `vld_sw`, `empty_next`.
- **Top level:** the demux decode, `curr_path` register and optional counter.

## Test plan
- **Basic route:** reset, `sw`=5, `vld_sw`=1, `clk_en`=1, `m05.ready`=1; send 0x11,0x22,0x33 back-to-back → `m05` receives 0x11,0x22,0x33 in consecutive cycles; all other valids stay 0.
- **Backpressure:** `m05.ready`=0 during 3 sends → `s00.ready` drops after the 2nd accept; release ready → exactly 2 words delivered in order, then the third is accepted.
- **Deferred switch:** `sw` changes 5→2 while 2 words are buffered → both exit on `m05`; `curr_path`=2 only after EMPTY; the next word exits on `m02`.
- **`clk_en` gating:** `clk_en`=0 for 4 cycles mid-stream → no transfers counted; data and valids hold; stream resumes intact with no duplicated or dropped words.
- **Reset mid-operation:** `rst_n`=0 while in FULL → next cycle `s00.ready`=0, all valids 0, `curr_path`=0.
- **Counter (`DATA_PIPE_DEMUX_CNT_EN`):** send 10 words on path 3 → `xfer_cnt`=10; switch to path 4 → `xfer_cnt`=0.
